// File: rtl/gb_if_sched.sv
// Round-robin scheduler for the shared GB<->IF port.
// Each accepted request gets one cfg handshake and then req_len beats, either on the
// write channel (GB->IF) or on the read channel (IF->GB).
module gb_if_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned PORT_WIDTH = 128,
  parameter int unsigned INFO_W     = 4,
  parameter int unsigned LEN_W      = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_val,
  input  logic [NUM_REQ-1:0]            req_dir,
  input  logic [NUM_REQ*INFO_W-1:0]     req_info,
  input  logic [NUM_REQ*LEN_W-1:0]      req_len,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [NUM_REQ-1:0]            req_done,
  input  logic [NUM_REQ-1:0]            gb_wr_val,
  input  logic [NUM_REQ*PORT_WIDTH-1:0] gb_wr_data,
  output logic [NUM_REQ-1:0]            gb_wr_rdy,
  output logic [NUM_REQ-1:0]            gb_rd_val,
  output logic [PORT_WIDTH-1:0]         gb_rd_data,
  input  logic [NUM_REQ-1:0]            gb_rd_rdy,
  output logic                          GBIF_cfg_val,
  input  logic                          IFGB_cfg_rdy,
  output logic [INFO_W-1:0]             GBIF_cfg_info,
  output logic                          GBIF_wr_val,
  input  logic                          IFGB_wr_rdy,
  output logic [PORT_WIDTH-1:0]         GBIF_wr_data,
  input  logic                          IFGB_rd_val,
  output logic                          GBIF_rd_rdy,
  input  logic [PORT_WIDTH-1:0]         IFGB_rd_data,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    cur_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_WR, S_RD, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic                    dir_q, dir_d;
  logic [INFO_W-1:0]       info_q, info_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic                    beat;

  logic                    arb_found;
  logic [IDX_W-1:0]        arb_idx;
  logic [IDX_W-1:0]        arb_k;
  int unsigned             arb_j;

  logic [PORT_WIDTH-1:0]   wr_slot   [NUM_REQ];
  logic [INFO_W-1:0]       info_slot [NUM_REQ];
  logic [LEN_W-1:0]        len_slot  [NUM_REQ];

  // Per-requester views of the packed request/data buses
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign wr_slot[g]   = gb_wr_data[g*PORT_WIDTH +: PORT_WIDTH];
    assign info_slot[g] = req_info[g*INFO_W +: INFO_W];
    assign len_slot[g]  = req_len[g*LEN_W +: LEN_W];
  end

  // Read data is broadcast; only the granted requester sees gb_rd_val
  assign gb_rd_data = IFGB_rd_data;
  assign busy       = (state_q != S_IDLE);
  assign cur_idx    = idx_q;

  // Round-robin pick: first pending requester at or above the pointer, wrapping
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_j     = 0;
    arb_k     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_j = (32'(rr_q) + 32'(k)) % NUM_REQ;
      arb_k = IDX_W'(arb_j);
      if (!arb_found && req_val[arb_k]) begin
        arb_found = 1'b1;
        arb_idx   = arb_k;
      end
    end
  end

  // State and transfer context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      dir_q   <= 1'b0;
      info_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      dir_q   <= dir_d;
      info_q  <= info_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, grant/done pulses and channel pass-through for the granted requester
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rr_d          = rr_q;
    dir_d         = dir_q;
    info_d        = info_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    beat          = 1'b0;
    req_gnt       = '0;
    req_done      = '0;
    gb_wr_rdy     = '0;
    gb_rd_val     = '0;
    GBIF_cfg_val  = 1'b0;
    GBIF_cfg_info = '0;
    GBIF_wr_val   = 1'b0;
    GBIF_wr_data  = '0;
    GBIF_rd_rdy   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          req_gnt[arb_idx] = 1'b1;
          idx_d            = arb_idx;
          dir_d            = req_dir[arb_idx];
          info_d           = info_slot[arb_idx];
          len_d            = len_slot[arb_idx];
          cnt_d            = '0;
          state_d          = S_CFG;
        end
      end
      S_CFG: begin
        GBIF_cfg_val  = 1'b1;
        GBIF_cfg_info = info_q;
        if (IFGB_cfg_rdy) begin
          if (len_q == '0) state_d = S_DONE;
          else if (dir_q)  state_d = S_WR;
          else             state_d = S_RD;
        end
      end
      S_WR: begin
        GBIF_wr_val      = gb_wr_val[idx_q];
        GBIF_wr_data     = wr_slot[idx_q];
        gb_wr_rdy[idx_q] = IFGB_wr_rdy;
        beat             = gb_wr_val[idx_q] & IFGB_wr_rdy;
      end
      S_RD: begin
        gb_rd_val[idx_q] = IFGB_rd_val;
        GBIF_rd_rdy      = gb_rd_rdy[idx_q];
        beat             = IFGB_rd_val & gb_rd_rdy[idx_q];
      end
      S_DONE: begin
        req_done[idx_q] = 1'b1;
        rr_d            = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Last beat ends the transfer, so the counter never reaches len
    if (beat) begin
      if (cnt_q == len_q - LEN_W'(1)) state_d = S_DONE;
      else                            cnt_d   = cnt_q + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_gb_if_sched.sv
// Bench for gb_if_sched: directed scenarios plus randomized traffic checked each cycle
// against a transaction-level model (pending requests, one in-flight transfer record).
module tb_gb_if_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 128;
  localparam int unsigned IW = 4;
  localparam int unsigned LW = 12;
  localparam int unsigned XW = 2;

  logic            clk, rst_n;
  logic [N-1:0]    req_val, req_dir, req_gnt, req_done;
  logic [N*IW-1:0] req_info;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    gb_wr_val, gb_wr_rdy, gb_rd_val, gb_rd_rdy;
  logic [N*PW-1:0] gb_wr_data;
  logic [PW-1:0]   gb_rd_data, GBIF_wr_data, IFGB_rd_data;
  logic            GBIF_cfg_val, IFGB_cfg_rdy, GBIF_wr_val, IFGB_wr_rdy;
  logic            IFGB_rd_val, GBIF_rd_rdy, busy;
  logic [IW-1:0]   GBIF_cfg_info;
  logic [XW-1:0]   cur_idx;

  gb_if_sched #(.NUM_REQ(N), .PORT_WIDTH(PW), .INFO_W(IW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_dir(req_dir), .req_info(req_info), .req_len(req_len),
    .req_gnt(req_gnt), .req_done(req_done),
    .gb_wr_val(gb_wr_val), .gb_wr_data(gb_wr_data), .gb_wr_rdy(gb_wr_rdy),
    .gb_rd_val(gb_rd_val), .gb_rd_data(gb_rd_data), .gb_rd_rdy(gb_rd_rdy),
    .GBIF_cfg_val(GBIF_cfg_val), .IFGB_cfg_rdy(IFGB_cfg_rdy), .GBIF_cfg_info(GBIF_cfg_info),
    .GBIF_wr_val(GBIF_wr_val), .IFGB_wr_rdy(IFGB_wr_rdy), .GBIF_wr_data(GBIF_wr_data),
    .IFGB_rd_val(IFGB_rd_val), .GBIF_rd_rdy(GBIF_rd_rdy), .IFGB_rd_data(IFGB_rd_data),
    .busy(busy), .cur_idx(cur_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters
  int n_cmp, n_err, cyc;

  // Requester side: pending request per slot, held until granted
  bit            p_val  [N];
  bit            p_dir  [N];
  logic [IW-1:0] p_info [N];
  int            p_len  [N];

  // Stimulus knobs
  int p_new, p_io, max_len;
  bit fix_info;

  // Reference model: round-robin pointer and the single in-flight transfer
  bit            m_act, m_cfg, m_dir;
  int            m_idx, m_rr, m_len, m_beats;
  logic [IW-1:0] m_info;

  // Observations of DUT outputs for directed checks
  int obs_gnt[$];
  int gnt_cyc, done_cyc, n_done_obs, rd_beats2;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit chance(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic zero_inputs();
    req_val = '0; req_dir = '0; req_info = '0; req_len = '0;
    gb_wr_val = '0; gb_wr_data = '0; gb_rd_rdy = '0;
    IFGB_cfg_rdy = 1'b0; IFGB_wr_rdy = 1'b0; IFGB_rd_val = 1'b0; IFGB_rd_data = '0;
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_cfg = 1'b0; m_dir = 1'b0;
    m_idx = 0; m_rr = 0; m_len = 0; m_beats = 0; m_info = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!p_val[i] && chance(p_new)) begin
        p_val[i]  = 1'b1;
        p_dir[i]  = 1'($urandom_range(1));
        p_info[i] = fix_info ? IW'(i + 1) : IW'($urandom);
        p_len[i]  = int'($urandom_range(max_len));
      end
      req_val[i]           = p_val[i];
      req_dir[i]           = p_dir[i];
      req_info[i*IW +: IW] = p_info[i];
      req_len[i*LW +: LW]  = LW'(p_len[i]);
      gb_wr_val[i]         = chance(p_io);
      gb_rd_rdy[i]         = chance(p_io);
    end
    for (int k = 0; k < int'(N*PW/32); k++) gb_wr_data[k*32 +: 32] = $urandom;
    for (int k = 0; k < int'(PW/32); k++) IFGB_rd_data[k*32 +: 32] = $urandom;
    IFGB_cfg_rdy = chance(p_io);
    IFGB_wr_rdy  = chance(p_io);
    IFGB_rd_val  = chance(p_io);
  endtask

  task automatic check_cycle();
    logic [N-1:0] e_gnt, e_done, e_wr_rdy, e_rd_val;
    logic         e_cfg, e_wr_val, e_rd_rdy, wr_ph, hs;
    int           pick, jj;
    e_gnt = '0; e_done = '0; e_wr_rdy = '0; e_rd_val = '0;
    e_cfg = 1'b0; e_wr_val = 1'b0; e_rd_rdy = 1'b0; wr_ph = 1'b0; hs = 1'b0;
    pick = -1; jj = 0;

    if (!m_act) begin
      for (int k = 0; k < int'(N); k++) begin
        jj = (m_rr + k) % int'(N);
        if (pick < 0 && req_val[jj]) pick = jj;
      end
    end
    if (pick >= 0) e_gnt[pick] = 1'b1;

    if (m_act) begin
      if (!m_cfg) e_cfg = 1'b1;
      else if (m_beats < m_len) begin
        if (m_dir) begin
          wr_ph            = 1'b1;
          e_wr_val         = gb_wr_val[m_idx];
          e_wr_rdy[m_idx]  = IFGB_wr_rdy;
          hs               = gb_wr_val[m_idx] & IFGB_wr_rdy;
        end else begin
          e_rd_val[m_idx]  = IFGB_rd_val;
          e_rd_rdy         = gb_rd_rdy[m_idx];
          hs               = IFGB_rd_val & gb_rd_rdy[m_idx];
        end
      end else e_done[m_idx] = 1'b1;
    end

    check("gnt",     PW'(req_gnt),      PW'(e_gnt));
    check("done",    PW'(req_done),     PW'(e_done));
    check("cfg_val", PW'(GBIF_cfg_val), PW'(e_cfg));
    if (e_cfg) check("cfg_info", PW'(GBIF_cfg_info), PW'(m_info));
    check("wr_val",  PW'(GBIF_wr_val),  PW'(e_wr_val));
    if (wr_ph) check("wr_data", GBIF_wr_data, gb_wr_data[m_idx*PW +: PW]);
    check("wr_rdy",  PW'(gb_wr_rdy),    PW'(e_wr_rdy));
    check("rd_val",  PW'(gb_rd_val),    PW'(e_rd_val));
    check("rd_rdy",  PW'(GBIF_rd_rdy),  PW'(e_rd_rdy));
    check("rd_data", gb_rd_data,        IFGB_rd_data);
    check("busy",    PW'(busy),         PW'(m_act));
    check("cur_idx", PW'(cur_idx),      PW'(m_idx));

    for (int i = 0; i < int'(N); i++) if (req_gnt[i]) obs_gnt.push_back(i);
    if (req_gnt != '0) gnt_cyc = cyc;
    if (req_done != '0) begin done_cyc = cyc; n_done_obs++; end
    if (gb_rd_val[2] && gb_rd_rdy[2]) rd_beats2++;

    if (pick >= 0) begin
      m_act = 1'b1; m_cfg = 1'b0; m_beats = 0;
      m_idx = pick; m_dir = req_dir[pick];
      m_info = req_info[pick*IW +: IW];
      m_len = int'(req_len[pick*LW +: LW]);
      p_val[pick] = 1'b0;
    end else if (m_act) begin
      if (!m_cfg) m_cfg = IFGB_cfg_rdy;
      else if (m_beats < m_len) begin
        if (hs) m_beats++;
      end else begin
        m_act = 1'b0;
        m_rr  = (m_idx + 1) % int'(N);
      end
    end
    cyc++;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},     PW'(req_gnt),       '0);
    check({tag, "_done"},    PW'(req_done),      '0);
    check({tag, "_cfgval"},  PW'(GBIF_cfg_val),  '0);
    check({tag, "_cfginfo"}, PW'(GBIF_cfg_info), '0);
    check({tag, "_wrval"},   PW'(GBIF_wr_val),   '0);
    check({tag, "_wrdata"},  GBIF_wr_data,       '0);
    check({tag, "_wrrdy"},   PW'(gb_wr_rdy),     '0);
    check({tag, "_rdval"},   PW'(gb_rd_val),     '0);
    check({tag, "_rdrdy"},   PW'(GBIF_rd_rdy),   '0);
    check({tag, "_rddata"},  gb_rd_data,         '0);
    check({tag, "_busy"},    PW'(busy),          '0);
    check({tag, "_idx"},     PW'(cur_idx),       '0);
  endtask

  // Async reset; keep=1 leaves requester/IF inputs active to model an abort
  task automatic do_reset(input bit keep, input string tag);
    rst_n = 1'b0;
    if (!keep) begin
      zero_inputs();
      for (int i = 0; i < int'(N); i++) p_val[i] = 1'b0;
    end
    IFGB_rd_data = '0;
    #2;
    check_zero(tag);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit dir, input logic [IW-1:0] info, input int len);
    p_val[i] = 1'b1; p_dir[i] = dir; p_info[i] = info; p_len[i] = len;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    gnt_cyc = -1; done_cyc = -1; n_done_obs = 0; rd_beats2 = 0;
    p_new = 0; p_io = 100; max_len = 6; fix_info = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      p_val[i] = 1'b0; p_dir[i] = 1'b0; p_info[i] = '0; p_len[i] = 0;
    end
    rst_n = 1'b0;
    zero_inputs();
    model_reset();
    #1;
    do_reset(1'b0, "rst0");

    // Req0 write of 3 beats, IF always ready
    p_new = 0; p_io = 100;
    obs_gnt.delete(); gnt_cyc = -1; done_cyc = -1; n_done_obs = 0;
    set_req(0, 1'b1, 4'h9, 3);
    for (int s = 0; s < 20 && done_cyc < 0; s++) step();
    repeat (3) step();
    check("t1_latency", PW'(done_cyc - gnt_cyc), PW'(5));
    check("t1_ngnt",    PW'(obs_gnt.size()),     PW'(1));
    check("t1_gnt_idx", PW'(obs_gnt.size() > 0 ? obs_gnt[0] : -1), PW'(0));
    check("t1_ndone",   PW'(n_done_obs),         PW'(1));

    // Req2 read of 4 beats with gapped IF valid
    p_io = 55;
    done_cyc = -1; n_done_obs = 0; rd_beats2 = 0;
    set_req(2, 1'b0, 4'h6, 4);
    for (int s = 0; s < 300 && done_cyc < 0; s++) step();
    repeat (4) step();
    check("t2_beats", PW'(rd_beats2),  PW'(4));
    check("t2_ndone", PW'(n_done_obs), PW'(1));

    // All requesters held: grant order 0,1,2,3,0
    do_reset(1'b0, "rst3");
    p_new = 100; p_io = 100; fix_info = 1'b1; max_len = 2;
    obs_gnt.delete();
    for (int s = 0; s < 100 && obs_gnt.size() < 5; s++) step();
    for (int k = 0; k < 5; k++)
      check($sformatf("t3_gnt%0d", k), PW'(k < obs_gnt.size() ? obs_gnt[k] : -1), PW'(k % 4));

    // Reset in the middle of a write aborts and restarts round-robin at 0
    do_reset(1'b0, "rst6a");
    p_new = 0; fix_info = 1'b0; p_io = 100;
    n_done_obs = 0;
    set_req(1, 1'b1, 4'h3, 1);
    for (int s = 0; s < 20 && n_done_obs < 1; s++) step();
    check("t6_pre_done", PW'(n_done_obs), PW'(1));
    n_done_obs = 0;
    set_req(0, 1'b1, 4'hA, 8);
    for (int s = 0; s < 20 && !(m_act && m_beats == 2); s++) step();
    do_reset(1'b1, "rst6b");
    check("t6_nodone", PW'(n_done_obs), PW'(0));
    set_req(0, 1'b1, 4'hA, 8);
    set_req(2, 1'b0, 4'h5, 2);
    obs_gnt.delete();
    step();
    check("t6_regnt", PW'(obs_gnt.size() > 0 ? obs_gnt[0] : -1), PW'(0));

    // Randomized traffic
    p_new = 25; max_len = 6;
    p_io = 70;  repeat (1500) step();
    p_io = 35;  repeat (1500) step();
    p_io = 100; repeat (1000) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
